bytewrite_sp_ram_cfg: RTL and testbench
=======================================

Name: bytewrite_sp_ram_cfg

Overview:
Parametrised single-port block RAM with per-byte (column) write enables and a selectable write mode: WRITE_FIRST, READ_FIRST or NO_CHANGE. It has an optional output pipeline register and a read-valid strobe that tracks the configured latency. It replaces fixed 32x1024 write-first RAMs in datapath buffers and maps onto FPGA BRAM byte-enable primitives.

Parameters:
NUM_COL, 4, number of byte-enable columns
COL_WIDTH, 8, bits per column
ADDR_WIDTH, 10, address bits; depth = 2**ADDR_WIDTH
DATA_WIDTH, NUM_COL*COL_WIDTH, derived word width; do not override
WRITE_MODE, 0, output behaviour on a write cycle: 0 = WRITE_FIRST, 1 = READ_FIRST, 2 = NO_CHANGE
OUT_REG, 0, 1 adds one output pipeline stage (read latency 2)

Ports:
clk  input  1  clock; all logic on the rising edge
rst_n  input  1  reset; synchronous, active-low
ena  input  1  port enable; no read or write occurs when low
we  input  NUM_COL  per-column write enable; bit i writes din[i*COL_WIDTH +: COL_WIDTH]
addr  input  ADDR_WIDTH  word address
din  input  DATA_WIDTH  write data
dout  output  DATA_WIDTH  read data
dout_vld  output  1  high for exactly the cycles in which dout presents a newly updated read result

Behaviour:
- Reset is synchronous and active-low.
  - rst_n=0 at an edge: dout=0, dout_vld=0, pipeline stage and its valid flag cleared.
  - Memory contents are not cleared.
  - Writes are suppressed in any cycle where rst_n=0.
  - Reset mid-read discards the in-flight result; there is no valid pulse for it after release.
- Memory is the array `ram[0:2**ADDR_WIDTH-1]`, hierarchically accessible so benches can preload it. Power-up contents are undefined.
- Write: at an edge with ena=1 and we[i]=1, ram[addr] column i takes the matching din column. Columns with we[i]=0 are unchanged.
- Read stage 1 (edge with ena=1) depends on WRITE_MODE:
  - WRITE_FIRST: stage-1 data = merged word (new din on enabled columns, old contents elsewhere). This equals ram[addr] after the write.
  - READ_FIRST: stage-1 data = ram[addr] before the write.
  - NO_CHANGE: when we=0, stage-1 data = ram[addr]. When we!=0, stage-1 data holds its previous value and the stage-1 valid flag is 0.
  - A read-only cycle (we=0) returns ram[addr] in all modes.
- ena=0: stage 1 holds its data; stage-1 valid = 0.
- OUT_REG=0:
  - dout = stage-1 data, latency 1 cycle.
  - dout_vld = stage-1 valid.
- OUT_REG=1:
  - Stage 2 registers stage-1 data only when stage-1 valid=1, otherwise it holds.
  - dout = stage-2 data, latency 2 cycles.
  - dout_vld = stage-1 valid delayed by one cycle.
- dout never changes in a cycle where dout_vld=0, except on reset.
- Back-to-back accesses at full rate are supported, with no bubbles.
- Read-after-write to the same address in the next cycle returns the written data in all modes.
- All addresses are legal; there is no wrap logic because the depth is an exact power of two.
- Illegal WRITE_MODE (>2) or OUT_REG (>1) must stop elaboration via a generate-time check.

Test Plan:
1. Defaults, RAM preloaded to 0, mode WRITE_FIRST.
   - Cycle 1: ena=1, we=4'b1010, addr=1, din=32'hC04040D5.
   - Next edge: dout=32'hC0004000, dout_vld=1.
   - Then we=4'b0101 at the same address and data: dout=32'hC04040D5.
2. WRITE_MODE=1, ram[2]=32'h11223344.
   - Write we=4'b1111, din=32'hAABBCCDD, addr=2: dout=32'h11223344.
   - Following read of addr 2: dout=32'hAABBCCDD.
3. WRITE_MODE=2.
   - Read addr 3 (ram=32'h55): dout=32'h55, vld=1.
   - Then write addr 3 with we=4'hF, din=32'h77: dout stays 32'h55, dout_vld=0.
   - Next read of addr 3: dout=32'h77, vld=1.
4. OUT_REG=1, reads of addr 1, 2, 3 on consecutive cycles with ena=1, we=0.
   - dout_vld high 2 cycles after the first read, for 3 consecutive cycles.
   - dout sequence matches ram[1], ram[2], ram[3].
5. ena=0 for 3 cycles after a read: dout holds its last value, dout_vld=0, and no memory change even with we=4'hF.
6. Reset mid-operation, OUT_REG=1.
   - Issue a read, then assert rst_n=0 on the next edge: dout=0, dout_vld=0, and no stale valid after release.
   - A write with rst_n=0 leaves ram unchanged.
   - Preloaded contents survive reset.

Source files
------------

// File: rtl/bytewrite_sp_ram_cfg.sv
// Single-port block RAM with per-column write enables.
// The write-cycle output behaviour is selectable: WRITE_FIRST, READ_FIRST or NO_CHANGE.
// An optional output register stage is available.
// dout_vld marks every cycle in which dout carries a freshly updated read result.
module bytewrite_sp_ram_cfg #(
  parameter int NUM_COL    = 4,
  parameter int COL_WIDTH  = 8,
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = NUM_COL * COL_WIDTH,
  parameter int WRITE_MODE = 0,
  parameter int OUT_REG    = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ena,
  input  logic [NUM_COL-1:0]    we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dout_vld
);

  localparam int MODE_WRITE_FIRST = 0;
  localparam int MODE_READ_FIRST  = 1;
  localparam int MODE_NO_CHANGE   = 2;

  // Reject unsupported configurations while elaborating.
  if (WRITE_MODE > 2 || WRITE_MODE < 0) begin : g_bad_write_mode
    $fatal(1, "bytewrite_sp_ram_cfg: WRITE_MODE must be 0, 1 or 2");
  end
  if (OUT_REG > 1 || OUT_REG < 0) begin : g_bad_out_reg
    $fatal(1, "bytewrite_sp_ram_cfg: OUT_REG must be 0 or 1");
  end

  // Contents are not reset; benches may preload this array hierarchically.
  logic [DATA_WIDTH-1:0] ram [0:2**ADDR_WIDTH-1];

  logic [DATA_WIDTH-1:0] rd_word;
  logic [DATA_WIDTH-1:0] merged_word;
  logic [DATA_WIDTH-1:0] s1_data;
  logic                  s1_vld;

  // Current word at addr, plus the word as it will look after this cycle's write.
  always_comb begin
    rd_word     = ram[addr];
    merged_word = rd_word;
    for (int i = 0; i < NUM_COL; i++) begin
      if (we[i]) merged_word[i*COL_WIDTH +: COL_WIDTH] = din[i*COL_WIDTH +: COL_WIDTH];
    end
  end

  // Column-wise memory write; writes are blocked while reset is asserted.
  always_ff @(posedge clk) begin
    if (rst_n && ena) begin
      for (int i = 0; i < NUM_COL; i++) begin
        if (we[i]) ram[addr][i*COL_WIDTH +: COL_WIDTH] <= din[i*COL_WIDTH +: COL_WIDTH];
      end
    end
  end

  // Stage-1 read register.
  // In NO_CHANGE mode a write leaves the data untouched and raises no valid.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_data <= '0;
      s1_vld  <= 1'b0;
    end else if (ena) begin
      if (WRITE_MODE == MODE_WRITE_FIRST) begin
        s1_data <= merged_word;
        s1_vld  <= 1'b1;
      end else if (WRITE_MODE == MODE_READ_FIRST) begin
        s1_data <= rd_word;
        s1_vld  <= 1'b1;
      end else if (we == '0) begin
        s1_data <= rd_word;
        s1_vld  <= 1'b1;
      end else begin
        s1_vld  <= 1'b0;
      end
    end else begin
      s1_vld <= 1'b0;
    end
  end

  if (OUT_REG == 1) begin : g_out_reg
    logic [DATA_WIDTH-1:0] s2_data;
    logic                  s2_vld;

    // Stage 2 captures only valid results, so dout moves only when dout_vld is high.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        s2_data <= '0;
        s2_vld  <= 1'b0;
      end else begin
        if (s1_vld) s2_data <= s1_data;
        s2_vld <= s1_vld;
      end
    end

    assign dout     = s2_data;
    assign dout_vld = s2_vld;
  end else begin : g_no_out_reg
    assign dout     = s1_data;
    assign dout_vld = s1_vld;
  end

endmodule

// File: tb/tb_bytewrite_sp_ram_cfg.sv
// Directed bench for bytewrite_sp_ram_cfg.
// Four instances share one stimulus bus: WRITE_FIRST, READ_FIRST, NO_CHANGE,
// and WRITE_FIRST with the output register enabled.
module tb_bytewrite_sp_ram_cfg;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ena;
  logic [3:0]  we;
  logic [9:0]  addr;
  logic [31:0] din;

  logic [31:0] dout_wf, dout_rf, dout_nc, dout_or;
  logic        vld_wf, vld_rf, vld_nc, vld_or;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  bytewrite_sp_ram_cfg #(.WRITE_MODE(0), .OUT_REG(0)) u_wf (
    .clk(clk), .rst_n(rst_n), .ena(ena), .we(we), .addr(addr), .din(din),
    .dout(dout_wf), .dout_vld(vld_wf));
  bytewrite_sp_ram_cfg #(.WRITE_MODE(1), .OUT_REG(0)) u_rf (
    .clk(clk), .rst_n(rst_n), .ena(ena), .we(we), .addr(addr), .din(din),
    .dout(dout_rf), .dout_vld(vld_rf));
  bytewrite_sp_ram_cfg #(.WRITE_MODE(2), .OUT_REG(0)) u_nc (
    .clk(clk), .rst_n(rst_n), .ena(ena), .we(we), .addr(addr), .din(din),
    .dout(dout_nc), .dout_vld(vld_nc));
  bytewrite_sp_ram_cfg #(.WRITE_MODE(0), .OUT_REG(1)) u_or (
    .clk(clk), .rst_n(rst_n), .ena(ena), .we(we), .addr(addr), .din(din),
    .dout(dout_or), .dout_vld(vld_or));

  // One rising edge; inputs change and outputs are sampled 1 ns afterwards.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic e, input logic [3:0] w, input logic [9:0] a, input logic [31:0] d);
    ena = e; we = w; addr = a; din = d;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b0, 4'h0, 10'd0, 32'h0);
    step(); step();
    tests++; if (dout_wf !== 32'h0 || vld_wf !== 1'b0) begin fails++; $display("FAIL reset_wf: dout=%h vld=%b required 0/0", dout_wf, vld_wf); end
    tests++; if (dout_rf !== 32'h0 || vld_rf !== 1'b0) begin fails++; $display("FAIL reset_rf: dout=%h vld=%b required 0/0", dout_rf, vld_rf); end
    tests++; if (dout_nc !== 32'h0 || vld_nc !== 1'b0) begin fails++; $display("FAIL reset_nc: dout=%h vld=%b required 0/0", dout_nc, vld_nc); end
    tests++; if (dout_or !== 32'h0 || vld_or !== 1'b0) begin fails++; $display("FAIL reset_or: dout=%h vld=%b required 0/0", dout_or, vld_or); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_write_first();
    drive(1'b1, 4'b1010, 10'd1, 32'hC04040D5);
    step();
    tests++; if (dout_wf !== 32'hC0004000 || vld_wf !== 1'b1) begin fails++; $display("FAIL wf_partial: dout=%h vld=%b required C0004000/1", dout_wf, vld_wf); end
    drive(1'b1, 4'b0101, 10'd1, 32'hC04040D5);
    step();
    tests++; if (dout_wf !== 32'hC04040D5 || vld_wf !== 1'b1) begin fails++; $display("FAIL wf_merge: dout=%h vld=%b required C04040D5/1", dout_wf, vld_wf); end
    drive(1'b0, 4'h0, 10'd0, 32'h0);
    step();
  endtask

  task automatic test_read_first();
    u_rf.ram[2] = 32'h11223344;
    u_wf.ram[2] = 32'h0;
    drive(1'b1, 4'hF, 10'd2, 32'hAABBCCDD);
    step();
    tests++; if (dout_rf !== 32'h11223344 || vld_rf !== 1'b1) begin fails++; $display("FAIL rf_old_data: dout=%h vld=%b required 11223344/1", dout_rf, vld_rf); end
    tests++; if (dout_wf !== 32'hAABBCCDD) begin fails++; $display("FAIL wf_full_write: dout=%h required AABBCCDD", dout_wf); end
    drive(1'b1, 4'h0, 10'd2, 32'h0);
    step();
    tests++; if (dout_rf !== 32'hAABBCCDD || vld_rf !== 1'b1) begin fails++; $display("FAIL rf_raw: dout=%h vld=%b required AABBCCDD/1", dout_rf, vld_rf); end
    drive(1'b0, 4'h0, 10'd0, 32'h0);
    step();
  endtask

  task automatic test_no_change();
    u_nc.ram[3] = 32'h55;
    drive(1'b1, 4'h0, 10'd3, 32'h0);
    step();
    tests++; if (dout_nc !== 32'h55 || vld_nc !== 1'b1) begin fails++; $display("FAIL nc_read: dout=%h vld=%b required 55/1", dout_nc, vld_nc); end
    drive(1'b1, 4'hF, 10'd3, 32'h77);
    step();
    tests++; if (dout_nc !== 32'h55 || vld_nc !== 1'b0) begin fails++; $display("FAIL nc_write_hold: dout=%h vld=%b required 55/0", dout_nc, vld_nc); end
    drive(1'b1, 4'h0, 10'd3, 32'h0);
    step();
    tests++; if (dout_nc !== 32'h77 || vld_nc !== 1'b1) begin fails++; $display("FAIL nc_raw: dout=%h vld=%b required 77/1", dout_nc, vld_nc); end
    drive(1'b0, 4'h0, 10'd0, 32'h0);
    step();
  endtask

  task automatic test_out_reg_back_to_back();
    u_or.ram[1] = 32'hA1A1A1A1;
    u_or.ram[2] = 32'hB2B2B2B2;
    u_or.ram[3] = 32'hC3C3C3C3;
    drive(1'b1, 4'h0, 10'd1, 32'h0);
    step();
    tests++; if (vld_or !== 1'b0) begin fails++; $display("FAIL or_latency1: vld=%b required 0", vld_or); end
    drive(1'b1, 4'h0, 10'd2, 32'h0);
    step();
    tests++; if (dout_or !== 32'hA1A1A1A1 || vld_or !== 1'b1) begin fails++; $display("FAIL or_first: dout=%h vld=%b required A1A1A1A1/1", dout_or, vld_or); end
    drive(1'b1, 4'h0, 10'd3, 32'h0);
    step();
    tests++; if (dout_or !== 32'hB2B2B2B2 || vld_or !== 1'b1) begin fails++; $display("FAIL or_second: dout=%h vld=%b required B2B2B2B2/1", dout_or, vld_or); end
    drive(1'b0, 4'h0, 10'd0, 32'h0);
    step();
    tests++; if (dout_or !== 32'hC3C3C3C3 || vld_or !== 1'b1) begin fails++; $display("FAIL or_third: dout=%h vld=%b required C3C3C3C3/1", dout_or, vld_or); end
    step();
    tests++; if (dout_or !== 32'hC3C3C3C3 || vld_or !== 1'b0) begin fails++; $display("FAIL or_drain: dout=%h vld=%b required C3C3C3C3/0", dout_or, vld_or); end
  endtask

  task automatic test_enable_low();
    u_wf.ram[5] = 32'h12345678;
    drive(1'b1, 4'h0, 10'd5, 32'h0);
    step();
    tests++; if (dout_wf !== 32'h12345678 || vld_wf !== 1'b1) begin fails++; $display("FAIL ena_pre_read: dout=%h vld=%b required 12345678/1", dout_wf, vld_wf); end
    drive(1'b0, 4'hF, 10'd5, 32'hFFFFFFFF);
    for (int i = 0; i < 3; i++) begin
      step();
      tests++; if (dout_wf !== 32'h12345678 || vld_wf !== 1'b0) begin fails++; $display("FAIL ena_low_hold[%0d]: dout=%h vld=%b required 12345678/0", i, dout_wf, vld_wf); end
    end
    tests++; if (u_wf.ram[5] !== 32'h12345678) begin fails++; $display("FAIL ena_low_mem: ram=%h required 12345678", u_wf.ram[5]); end
    drive(1'b1, 4'h0, 10'd5, 32'h0);
    step();
    tests++; if (dout_wf !== 32'h12345678 || vld_wf !== 1'b1) begin fails++; $display("FAIL ena_post_read: dout=%h vld=%b required 12345678/1", dout_wf, vld_wf); end
    drive(1'b0, 4'h0, 10'd0, 32'h0);
    step();
  endtask

  task automatic test_reset_mid_read();
    u_or.ram[7] = 32'hDEADBEEF;
    drive(1'b1, 4'h0, 10'd7, 32'h0);
    step();
    rst_n = 1'b0;
    drive(1'b1, 4'hF, 10'd7, 32'h0);
    step();
    tests++; if (dout_or !== 32'h0 || vld_or !== 1'b0) begin fails++; $display("FAIL mid_reset_out: dout=%h vld=%b required 0/0", dout_or, vld_or); end
    rst_n = 1'b1;
    drive(1'b0, 4'h0, 10'd0, 32'h0);
    step();
    tests++; if (dout_or !== 32'h0 || vld_or !== 1'b0) begin fails++; $display("FAIL mid_reset_stale1: dout=%h vld=%b required 0/0", dout_or, vld_or); end
    step();
    tests++; if (dout_or !== 32'h0 || vld_or !== 1'b0) begin fails++; $display("FAIL mid_reset_stale2: dout=%h vld=%b required 0/0", dout_or, vld_or); end
    tests++; if (u_or.ram[7] !== 32'hDEADBEEF) begin fails++; $display("FAIL reset_write_blocked: ram=%h required DEADBEEF", u_or.ram[7]); end
    tests++; if (u_or.ram[1] !== 32'hA1A1A1A1) begin fails++; $display("FAIL reset_keeps_mem: ram=%h required A1A1A1A1", u_or.ram[1]); end
    drive(1'b1, 4'h0, 10'd7, 32'h0);
    step();
    drive(1'b0, 4'h0, 10'd0, 32'h0);
    step();
    tests++; if (dout_or !== 32'hDEADBEEF || vld_or !== 1'b1) begin fails++; $display("FAIL post_reset_read: dout=%h vld=%b required DEADBEEF/1", dout_or, vld_or); end
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 4'h0, 10'd0, 32'h0);
    for (int i = 0; i < 1024; i++) begin
      u_wf.ram[i] = 32'h0;
      u_rf.ram[i] = 32'h0;
      u_nc.ram[i] = 32'h0;
      u_or.ram[i] = 32'h0;
    end
    test_reset();
    test_write_first();
    test_read_first();
    test_no_change();
    test_out_reg_back_to_back();
    test_enable_low();
    test_reset_mid_read();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
